// File: rtl/ctrl_fir_datapath.sv
// 3-tap signed FIR stage driven by the sequencer's capture/publish strobes.
// A registered product stage sits between capture and publish to fit the two-cycle strobe spacing.
module ctrl_fir_datapath #(
    parameter int W    = 8,
    parameter int CW   = 8,
    parameter int FRAC = 6
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_in_i,
    input  logic                 en_out_i,
    input  logic signed [W-1:0]  din_i,
    input  logic signed [CW-1:0] b0_i,
    input  logic signed [CW-1:0] b1_i,
    input  logic signed [CW-1:0] b2_i,
    output logic signed [W-1:0]  dout_o,
    output logic                 dout_valid_o,
    output logic                 ovf_o,
    output logic                 seq_err_o
);

    localparam int PW = W + CW;
    localparam int SW = PW + 2;

    localparam logic signed [SW-1:0] SUM_MAX = {{(SW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [SW-1:0] SUM_MIN = {{(SW-W+1){1'b1}}, {(W-1){1'b0}}};
    localparam logic signed [W-1:0]  OUT_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0]  OUT_MIN = {1'b1, {(W-1){1'b0}}};

    logic signed [W-1:0]  x0_q, x1_q, x2_q;
    logic signed [PW-1:0] p0_q, p1_q, p2_q;
    logic                 pending_q, prod_rdy_q;
    logic signed [W-1:0]  dout_q;
    logic                 dout_valid_q, ovf_q, seq_err_q;

    logic                 accept_d, reject_d, sat_hit_d;
    logic signed [SW-1:0] sum_d, shr_d;
    logic signed [W-1:0]  dout_d;

    function automatic logic signed [PW-1:0] mul(input logic signed [W-1:0]  x,
                                                  input logic signed [CW-1:0] b);
        logic signed [PW-1:0] xe, be;
        xe = {{CW{x[W-1]}}, x};
        be = {{W{b[CW-1]}}, b};
        return xe * be;
    endfunction

    always_comb begin
        accept_d  = en_out_i & prod_rdy_q & ~en_in_i;
        reject_d  = en_out_i & ~accept_d;
        sum_d     = $signed({{2{p0_q[PW-1]}}, p0_q})
                  + $signed({{2{p1_q[PW-1]}}, p1_q})
                  + $signed({{2{p2_q[PW-1]}}, p2_q});
        shr_d     = sum_d >>> FRAC;
        sat_hit_d = 1'b0;
        dout_d    = shr_d[W-1:0];
        if (shr_d > SUM_MAX) begin
            dout_d    = OUT_MAX;
            sat_hit_d = 1'b1;
        end else if (shr_d < SUM_MIN) begin
            dout_d    = OUT_MIN;
            sat_hit_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            x0_q         <= '0;
            x1_q         <= '0;
            x2_q         <= '0;
            p0_q         <= '0;
            p1_q         <= '0;
            p2_q         <= '0;
            pending_q    <= 1'b0;
            prod_rdy_q   <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            ovf_q        <= 1'b0;
            seq_err_q    <= 1'b0;
        end else begin
            // Products always track the current history; prod_rdy marks them as fresh.
            p0_q         <= mul(x0_q, b0_i);
            p1_q         <= mul(x1_q, b1_i);
            p2_q         <= mul(x2_q, b2_i);
            prod_rdy_q   <= pending_q & ~en_in_i;
            dout_valid_q <= accept_d;
            if (en_in_i) begin
                x2_q      <= x1_q;
                x1_q      <= x0_q;
                x0_q      <= din_i;
                pending_q <= 1'b1;
            end
            if (accept_d) begin
                dout_q     <= dout_d;
                pending_q  <= 1'b0;
                prod_rdy_q <= 1'b0;
                if (sat_hit_d) ovf_q <= 1'b1;
            end
            if (reject_d) seq_err_q <= 1'b1;
        end
    end

    assign dout_o       = dout_q;
    assign dout_valid_o = dout_valid_q;
    assign ovf_o        = ovf_q;
    assign seq_err_o    = seq_err_q;

endmodule
